dds_voice_scheduler: RTL and testbench

Sequencer and update arbiter for the shared DDS phase-accumulator RAM. Once per audio frame it walks every voice through the DDS three-phase pipeline (read, compute/write-back, update), collects each voice's 10-bit phase, and forwards at most one tuning-code update per voice slot. Updates are paced so the DDS single-entry update buffer never drops one. It sits between the MIDI/SPI command decoder (upstream) and the DDS core plus the waveform stage (downstream).

---
 rtl/dds_voice_scheduler_if.sv | 29 ++
 rtl/dds_voice_scheduler.sv | 158 +++++++++++++++
 tb/tb_dds_voice_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_voice_scheduler_if.sv
// ----------------------------------------------------------------------------
// dds_voice_scheduler_if
// Upstream tuning-update handshake between the command decoder (master) and
// the DDS voice scheduler (slave).
//   upd_valid  master -> slave  update valid
//   upd_ready  slave  -> master update accepted when valid & ready
//   upd_voice  master -> slave  voice index of the update (8 bits)
//   upd_code   master -> slave  delta-phase tuning code (32 bits)
// ----------------------------------------------------------------------------
interface dds_voice_scheduler_if;
    logic        upd_valid;
    logic        upd_ready;
    logic [7:0]  upd_voice;
    logic [31:0] upd_code;

    modport master (
        output upd_valid,
        output upd_voice,
        output upd_code,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_voice,
        input  upd_code,
        output upd_ready
    );
endinterface

// File: rtl/dds_voice_scheduler.sv
// ----------------------------------------------------------------------------
// dds_voice_scheduler
// Once per audio frame, walks every voice through the DDS read / compute /
// update pipeline, captures each voice's phase and forwards at most one
// tuning-code update per voice slot to the DDS single-entry update buffer.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   o_pipeline_state          0 read, 1 compute, 2 update, 3 idle
//   o_voice_index             voice presented to the DDS
//   i_phase                   DDS phase output
//   i_voice_index_next        DDS registered voice index
//   o_phase, o_phase_voice    captured phase and its voice
//   o_phase_valid             one-cycle strobe for o_phase/o_phase_voice
//   o_frame_start             strobe in the first READ cycle of a frame
//   o_frame_done              strobe with the last o_phase_valid of a frame
//   o_overrun                 sticky: frame tick arrived while busy
//   upd_if (slave)            upstream tuning-update handshake
//   o_SPI_flag                one-cycle update strobe to the DDS
//   o_SPI_voice_index         update voice to the DDS (held)
//   o_SPI_tuning_code         update code to the DDS (held)
// ----------------------------------------------------------------------------
module dds_voice_scheduler #(
    parameter int unsigned NUM_VOICES = 64,
    parameter int unsigned SAMPLE_DIV = 1024
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    output logic [1:0]                  o_pipeline_state,
    output logic [7:0]                  o_voice_index,
    input  logic [9:0]                  i_phase,
    input  logic [7:0]                  i_voice_index_next,
    output logic [9:0]                  o_phase,
    output logic [7:0]                  o_phase_voice,
    output logic                        o_phase_valid,
    output logic                        o_frame_start,
    output logic                        o_frame_done,
    output logic                        o_overrun,
    dds_voice_scheduler_if.slave        upd_if,
    output logic                        o_SPI_flag,
    output logic [7:0]                  o_SPI_voice_index,
    output logic [31:0]                 o_SPI_tuning_code
);

    localparam int unsigned     DIV_W      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [7:0]      LAST_VOICE = 8'(NUM_VOICES - 1);

    // Encodings match the o_pipeline_state values so the state register
    // drives that output directly.
    typedef enum logic [1:0] {
        ST_READ    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_UPDATE  = 2'd2,
        ST_IDLE    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_voice;
    logic [7:0]       w_voice_next;
    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    logic             w_last;
    logic             r_upd_ready;
    logic             w_accept;

    assign w_tick   = (r_div == DIV_LAST);
    assign w_last   = (r_voice == LAST_VOICE);
    assign w_accept = r_upd_ready & upd_if.upd_valid;

    assign o_pipeline_state = r_state;
    assign o_voice_index    = r_voice;
    assign upd_if.upd_ready = r_upd_ready;

    // ------------------------------------------------------------------
    // Pipeline sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_voice <= '0;
        end else begin
            r_state <= w_state_next;
            r_voice <= w_voice_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_voice_next = r_voice;
        case (r_state)
            ST_IDLE: begin
                if (w_tick) begin
                    w_state_next = ST_READ;
                    w_voice_next = '0;
                end
            end
            ST_READ:    w_state_next = ST_COMPUTE;
            ST_COMPUTE: w_state_next = ST_UPDATE;
            ST_UPDATE: begin
                if (w_last) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_READ;
                    w_voice_next = r_voice + 8'd1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame divider, phase capture, update forwarding
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div             <= '0;
            r_upd_ready       <= 1'b0;
            o_phase           <= '0;
            o_phase_voice     <= '0;
            o_phase_valid     <= 1'b0;
            o_frame_start     <= 1'b0;
            o_frame_done      <= 1'b0;
            o_overrun         <= 1'b0;
            o_SPI_flag        <= 1'b0;
            o_SPI_voice_index <= '0;
            o_SPI_tuning_code <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;

            o_frame_start <= (r_state == ST_IDLE) && w_tick;
            if (w_tick && (r_state != ST_IDLE)) begin
                o_overrun <= 1'b1;
            end

            // Ready is registered one cycle ahead so it is high exactly
            // during UPDATE, giving one acceptance slot per voice.
            r_upd_ready <= (r_state == ST_COMPUTE);

            o_phase_valid <= (r_state == ST_UPDATE);
            o_frame_done  <= (r_state == ST_UPDATE) && w_last;
            if (r_state == ST_UPDATE) begin
                o_phase       <= i_phase;
                o_phase_voice <= i_voice_index_next;
            end

            // Flag lands in the following READ (or IDLE), so the DDS buffer
            // is always drained by its UPDATE before the next flag.
            o_SPI_flag <= w_accept;
            if (w_accept) begin
                o_SPI_voice_index <= upd_if.upd_voice;
                o_SPI_tuning_code <= upd_if.upd_code;
            end
        end
    end

endmodule

// File: tb/tb_dds_voice_scheduler.sv
module tb_dds_voice_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT 1: NUM_VOICES=4, SAMPLE_DIV=16
    logic [1:0]  st1;
    logic [7:0]  vi1, pv1, spiv1;
    logic [9:0]  ph1;
    logic        pvalid1, fs1, fd1, ov1, flag1;
    logic [31:0] spic1;
    logic [9:0]  m_phase;
    logic [7:0]  m_vnext;
    dds_voice_scheduler_if u_if1 ();

    // DUT 2: NUM_VOICES=4, SAMPLE_DIV=8 (overruns every frame)
    logic [1:0]  st2;
    logic [7:0]  vi2, pv2, spiv2;
    logic [9:0]  ph2;
    logic        pvalid2, fs2, fd2, ov2, flag2;
    logic [31:0] spic2;
    logic [9:0]  z10 = '0;
    logic [7:0]  z8  = '0;
    dds_voice_scheduler_if u_if2 ();

    dds_voice_scheduler #(.NUM_VOICES(4), .SAMPLE_DIV(16)) u_dut1 (
        .i_clk(clk), .i_reset(rst),
        .o_pipeline_state(st1), .o_voice_index(vi1),
        .i_phase(m_phase), .i_voice_index_next(m_vnext),
        .o_phase(ph1), .o_phase_voice(pv1), .o_phase_valid(pvalid1),
        .o_frame_start(fs1), .o_frame_done(fd1), .o_overrun(ov1),
        .upd_if(u_if1.slave),
        .o_SPI_flag(flag1), .o_SPI_voice_index(spiv1), .o_SPI_tuning_code(spic1)
    );

    dds_voice_scheduler #(.NUM_VOICES(4), .SAMPLE_DIV(8)) u_dut2 (
        .i_clk(clk), .i_reset(rst),
        .o_pipeline_state(st2), .o_voice_index(vi2),
        .i_phase(z10), .i_voice_index_next(z8),
        .o_phase(ph2), .o_phase_voice(pv2), .o_phase_valid(pvalid2),
        .o_frame_start(fs2), .o_frame_done(fd2), .o_overrun(ov2),
        .upd_if(u_if2.slave),
        .o_SPI_flag(flag2), .o_SPI_voice_index(spiv2), .o_SPI_tuning_code(spic2)
    );

    // Small DDS model: per-voice accumulator, phase = acc[31:22],
    // single-entry update buffer drained in the UPDATE cycle.
    logic [31:0] m_acc   [4];
    logic [31:0] m_delta [4];
    logic        m_pend;
    logic [7:0]  m_bvoice;
    logic [31:0] m_bcode;
    int          m_lost;
    logic [31:0] m_sum;

    assign m_sum = m_acc[vi1[1:0]] + m_delta[vi1[1:0]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) m_acc[i] <= '0;
            m_delta[0] <= '0;
            m_delta[1] <= '0;
            m_delta[2] <= 32'h0040_0000;
            m_delta[3] <= '0;
            m_phase    <= '0;
            m_vnext    <= '0;
            m_pend     <= 1'b0;
            m_bvoice   <= '0;
            m_bcode    <= '0;
            m_lost     <= 0;
        end else begin
            if (st1 == 2'd1) begin
                m_acc[vi1[1:0]] <= m_sum;
                m_phase         <= m_sum[31:22];
                m_vnext         <= vi1;
            end
            if (st1 == 2'd2 && m_pend) begin
                if (m_bvoice < 8'd4) m_delta[m_bvoice[1:0]] <= m_bcode;
                m_pend <= 1'b0;
            end
            if (flag1) begin
                if (m_pend && st1 != 2'd2) m_lost <= m_lost + 1;
                m_pend   <= 1'b1;
                m_bvoice <= spiv1;
                m_bcode  <= spic1;
            end
        end
    end

    // Returns cycles waited until dut1 frame start (0 if bound expired).
    task automatic wait_fs1(input int bound, output int waited);
        waited = 0;
        for (int n = 1; n <= bound; n++) begin
            @(negedge clk);
            if (fs1 === 1'b1) begin
                waited = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (st1 !== 2'd3) begin errors++; $display("FAIL reset_state got %0d want 3", st1); end
        checks++; if (vi1 !== 8'd0) begin errors++; $display("FAIL reset_voice got %0d want 0", vi1); end
        checks++; if (ph1 !== 10'd0) begin errors++; $display("FAIL reset_phase got %0d want 0", ph1); end
        checks++; if (pv1 !== 8'd0) begin errors++; $display("FAIL reset_phase_voice got %0d want 0", pv1); end
        checks++; if (pvalid1 !== 1'b0) begin errors++; $display("FAIL reset_phase_valid got %b want 0", pvalid1); end
        checks++; if (fs1 !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b want 0", fs1); end
        checks++; if (fd1 !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", fd1); end
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", ov1); end
        checks++; if (u_if1.upd_ready !== 1'b0) begin errors++; $display("FAIL reset_upd_ready got %b want 0", u_if1.upd_ready); end
        checks++; if (flag1 !== 1'b0) begin errors++; $display("FAIL reset_spi_flag got %b want 0", flag1); end
        checks++; if (spiv1 !== 8'd0) begin errors++; $display("FAIL reset_spi_voice got %0d want 0", spiv1); end
        checks++; if (spic1 !== 32'd0) begin errors++; $display("FAIL reset_spi_code got %h want 0", spic1); end
        checks++; if (st2 !== 2'd3) begin errors++; $display("FAIL reset_state2 got %0d want 3", st2); end
    endtask

    task automatic test_sequence();
        int first = 0;
        int idle_cnt = 0;
        logic [1:0] exp_st;
        rst = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (st1 === 2'd0) begin
                first = n;
                break;
            end
            if (st1 === 2'd3) idle_cnt++;
        end
        checks++; if (first != 16) begin errors++; $display("FAIL seq_first_read got %0d want 16", first); end
        checks++; if (idle_cnt != 15) begin errors++; $display("FAIL seq_idle_cycles got %0d want 15", idle_cnt); end
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            exp_st = (c < 12) ? 2'(c % 3) : 2'd3;
            checks++; if (st1 !== exp_st) begin errors++; $display("FAIL seq_state c=%0d got %0d want %0d", c, st1, exp_st); end
            checks++; if (fs1 !== (c == 0)) begin errors++; $display("FAIL seq_frame_start c=%0d got %b want %b", c, fs1, (c == 0)); end
            if (c < 12) begin
                checks++; if (vi1 !== 8'(c / 3)) begin errors++; $display("FAIL seq_voice c=%0d got %0d want %0d", c, vi1, c / 3); end
            end
        end
    endtask

    task automatic test_phase();
        int waited;
        logic exp_valid;
        logic [7:0] exp_voice;
        logic [9:0] exp_phase;
        for (int f = 2; f <= 3; f++) begin
            wait_fs1(40, waited);
            checks++; if (waited != 1) begin errors++; $display("FAIL phase_frame_period f=%0d got %0d want 1", f, waited); end
            for (int c = 1; c < 16; c++) begin
                @(negedge clk);
                exp_valid = (c % 3 == 0) && (c <= 12);
                checks++; if (pvalid1 !== exp_valid) begin errors++; $display("FAIL phase_valid c=%0d got %b want %b", c, pvalid1, exp_valid); end
                checks++; if (fd1 !== (c == 12)) begin errors++; $display("FAIL frame_done c=%0d got %b want %b", c, fd1, (c == 12)); end
                if (exp_valid) begin
                    exp_voice = 8'(c / 3 - 1);
                    exp_phase = (exp_voice == 8'd2) ? 10'(f) : 10'd0;
                    checks++; if (pv1 !== exp_voice) begin errors++; $display("FAIL phase_voice c=%0d got %0d want %0d", c, pv1, exp_voice); end
                    checks++; if (ph1 !== exp_phase) begin errors++; $display("FAIL phase_value f=%0d c=%0d got %0d want %0d", f, c, ph1, exp_phase); end
                end
            end
        end
    endtask

    task automatic test_update();
        int waited;
        logic exp_rdy, exp_flag;
        u_if1.upd_valid = 1'b1;
        u_if1.upd_voice = 8'd1;
        u_if1.upd_code  = 32'h1234_5678;
        wait_fs1(40, waited);
        checks++; if (waited != 1) begin errors++; $display("FAIL upd_frame_period got %0d want 1", waited); end
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            exp_rdy  = (c % 3 == 2) && (c < 12);
            exp_flag = (c % 3 == 0) && (c >= 3) && (c <= 12);
            checks++; if (u_if1.upd_ready !== exp_rdy) begin errors++; $display("FAIL upd_ready c=%0d got %b want %b", c, u_if1.upd_ready, exp_rdy); end
            checks++; if (flag1 !== exp_flag) begin errors++; $display("FAIL spi_flag c=%0d got %b want %b", c, flag1, exp_flag); end
            if (c >= 3) begin
                checks++; if (spiv1 !== 8'd1) begin errors++; $display("FAIL spi_voice c=%0d got %0d want 1", c, spiv1); end
                checks++; if (spic1 !== 32'h1234_5678) begin errors++; $display("FAIL spi_code c=%0d got %h want 12345678", c, spic1); end
            end
        end
        u_if1.upd_valid = 1'b0;
        checks++; if (m_lost != 0) begin errors++; $display("FAIL upd_lost got %0d want 0", m_lost); end
        checks++; if (m_delta[1] !== 32'h1234_5678) begin errors++; $display("FAIL upd_applied got %h want 12345678", m_delta[1]); end
    endtask

    task automatic test_out_of_range();
        int waited;
        int rdy_at = 0;
        int bad = 0;
        wait_fs1(40, waited);
        checks++; if (waited != 1) begin errors++; $display("FAIL oor_frame_period got %0d want 1", waited); end
        u_if1.upd_valid = 1'b1;
        u_if1.upd_voice = 8'd9;
        u_if1.upd_code  = 32'hDEAD_BEEF;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (u_if1.upd_ready === 1'b1) begin
                rdy_at = k;
                break;
            end
        end
        checks++; if (rdy_at != 2) begin errors++; $display("FAIL oor_ready_cycle got %0d want 2", rdy_at); end
        @(negedge clk);
        u_if1.upd_valid = 1'b0;
        checks++; if (flag1 !== 1'b1) begin errors++; $display("FAIL oor_flag got %b want 1", flag1); end
        checks++; if (spiv1 !== 8'd9) begin errors++; $display("FAIL oor_voice got %0d want 9", spiv1); end
        checks++; if (spic1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL oor_code got %h want deadbeef", spic1); end
        for (int c = 4; c < 16; c++) begin
            @(negedge clk);
            if (flag1 !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL oor_extra_flags got %0d want 0", bad); end
        checks++; if (spiv1 !== 8'd9) begin errors++; $display("FAIL oor_voice_hold got %0d want 9", spiv1); end
        checks++; if (m_lost != 0) begin errors++; $display("FAIL oor_lost got %0d want 0", m_lost); end
    endtask

    task automatic test_overrun();
        int first = 0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL ovr_reset got %b want 0", ov2); end
        rst = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (fs2 === 1'b1) begin
                first = n;
                break;
            end
        end
        checks++; if (first != 8) begin errors++; $display("FAIL ovr_first_frame got %0d want 8", first); end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++; if (ov2 !== (c == 8)) begin errors++; $display("FAIL ovr_flag c=%0d got %b want %b", c, ov2, (c == 8)); end
        end
        checks++; if (st2 !== 2'd2) begin errors++; $display("FAIL ovr_tick_ignored_state got %0d want 2", st2); end
        checks++; if (vi2 !== 8'd2) begin errors++; $display("FAIL ovr_tick_ignored_voice got %0d want 2", vi2); end
        checks++; if (fs2 !== 1'b0) begin errors++; $display("FAIL ovr_no_restart got %b want 0", fs2); end
        repeat (40) @(negedge clk);
        checks++; if (ov2 !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", ov2); end
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL ovr_dut1 got %b want 0", ov1); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL ovr_cleared got %b want 0", ov2); end
        rst = 1'b0;
    endtask

    task automatic test_midframe_reset();
        int waited;
        int first = 0;
        int bad = 0;
        logic [73:0] got;
        wait_fs1(40, waited);
        checks++; if (waited != 16) begin errors++; $display("FAIL mid_first_frame got %0d want 16", waited); end
        u_if1.upd_valid = 1'b1;
        u_if1.upd_voice = 8'd2;
        u_if1.upd_code  = 32'hCAFE_F00D;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        got = {st1, vi1, ph1, pv1, pvalid1, fs1, fd1, ov1, u_if1.upd_ready, flag1, spiv1, spic1};
        checks++; if (got !== {2'd3, 72'd0}) begin errors++; $display("FAIL mid_reset_values got %h want %h", got, {2'd3, 72'd0}); end
        rst = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (st1 === 2'd0) begin
                first = n;
                break;
            end
            if (flag1 !== 1'b0 || pvalid1 !== 1'b0) bad++;
        end
        u_if1.upd_valid = 1'b0;
        checks++; if (first != 16) begin errors++; $display("FAIL mid_restart got %0d want 16", first); end
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_stale_strobes got %0d want 0", bad); end
        checks++; if (spic1 !== 32'd0) begin errors++; $display("FAIL mid_dropped_update got %h want 0", spic1); end
    endtask

    initial begin
        u_if1.upd_valid = 1'b0;
        u_if1.upd_voice = '0;
        u_if1.upd_code  = '0;
        u_if2.upd_valid = 1'b0;
        u_if2.upd_voice = '0;
        u_if2.upd_code  = '0;
        test_reset();
        test_sequence();
        test_phase();
        test_update();
        test_out_of_range();
        test_overrun();
        test_midframe_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
